// File: rtl/structural_level.sv
// Registered two-input gate library stage: NOT/AND/OR/XOR/NAND/NOR/XNOR built from gate primitives.
// Optional registered invariant checker with sticky err output, enabled by STRUCTURAL_LEVEL_SELFCHECK_EN.
module structural_level #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c_not_a,
    output logic [WIDTH-1:0] c_not_b,
    output logic [WIDTH-1:0] c_and,
    output logic [WIDTH-1:0] c_or,
    output logic [WIDTH-1:0] c_xor,
    output logic [WIDTH-1:0] c_nand,
    output logic [WIDTH-1:0] c_nor,
`ifdef STRUCTURAL_LEVEL_SELFCHECK_EN
    output logic [WIDTH-1:0] c_xnor,
    output logic             err
`else
    output logic [WIDTH-1:0] c_xnor
`endif
);

    wire [WIDTH-1:0] not_a_n, not_b_n, and_n, or_n, xor_n, nand_n, nor_n, xnor_n;

    logic [WIDTH-1:0] not_a_q, not_b_q, and_q, or_q, xor_q, nand_q, nor_q, xnor_q;

    // One primitive per bit per function; bits never interact.
    for (genvar i = 0; i < WIDTH; i++) begin : g_gate
        not  u_not_a (not_a_n[i], a[i]);
        not  u_not_b (not_b_n[i], b[i]);
        and  u_and   (and_n[i],   a[i], b[i]);
        or   u_or    (or_n[i],    a[i], b[i]);
        xor  u_xor   (xor_n[i],   a[i], b[i]);
        nand u_nand  (nand_n[i],  a[i], b[i]);
        nor  u_nor   (nor_n[i],   a[i], b[i]);
        xnor u_xnor  (xnor_n[i],  a[i], b[i]);
    end

    // Reset zeroes everything, including the inverting outputs, and wins over en.
    always_ff @(posedge clk) begin
        if (rst) begin
            not_a_q <= '0;
            not_b_q <= '0;
            and_q   <= '0;
            or_q    <= '0;
            xor_q   <= '0;
            nand_q  <= '0;
            nor_q   <= '0;
            xnor_q  <= '0;
        end else if (en) begin
            not_a_q <= not_a_n;
            not_b_q <= not_b_n;
            and_q   <= and_n;
            or_q    <= or_n;
            xor_q   <= xor_n;
            nand_q  <= nand_n;
            nor_q   <= nor_n;
            xnor_q  <= xnor_n;
        end
    end

    assign c_not_a = not_a_q;
    assign c_not_b = not_b_q;
    assign c_and   = and_q;
    assign c_or    = or_q;
    assign c_xor   = xor_q;
    assign c_nand  = nand_q;
    assign c_nor   = nor_q;
    assign c_xnor  = xnor_q;

`ifdef STRUCTURAL_LEVEL_SELFCHECK_EN
    wire [WIDTH-1:0] v_nand, v_nor, v_xnor, t_not, v_not, v_any;
    logic            cap_q;
    logic            err_q;

    // Each v_* bit is 1 when its invariant is broken on that bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_chk
        xnor u_v_nand (v_nand[i], nand_q[i], and_q[i]);
        xnor u_v_nor  (v_nor[i],  nor_q[i],  or_q[i]);
        xnor u_v_xnor (v_xnor[i], xnor_q[i], xor_q[i]);
        xor  u_t_not  (t_not[i],  not_a_q[i], not_b_q[i]);
        xor  u_v_not  (v_not[i],  t_not[i],   xor_q[i]);
        or   u_v_any  (v_any[i],  v_nand[i], v_nor[i], v_xnor[i], v_not[i]);
    end

    // Outputs are only meaningful after a capture, so the check is gated by cap_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            cap_q <= en;
            if (cap_q && (|v_any))
                err_q <= 1'b1;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_structural_level.sv
// Directed bench for structural_level at WIDTH=1 and WIDTH=4, with hand-computed expected vectors.
// Exercises the sticky checker when STRUCTURAL_LEVEL_SELFCHECK_EN is defined.
module tb_structural_level;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en1, en4;
    logic [0:0] a1, b1;
    logic [3:0] a4, b4;

    logic [0:0] n1_not_a, n1_not_b, n1_and, n1_or, n1_xor, n1_nand, n1_nor, n1_xnor;
    logic [3:0] n4_not_a, n4_not_b, n4_and, n4_or, n4_xor, n4_nand, n4_nor, n4_xnor;
`ifdef STRUCTURAL_LEVEL_SELFCHECK_EN
    logic err1, err4;
`endif

    structural_level #(.WIDTH(1)) u_d1 (
        .clk(clk), .rst(rst), .en(en1), .a(a1), .b(b1),
        .c_not_a(n1_not_a), .c_not_b(n1_not_b), .c_and(n1_and), .c_or(n1_or),
        .c_xor(n1_xor), .c_nand(n1_nand), .c_nor(n1_nor),
`ifdef STRUCTURAL_LEVEL_SELFCHECK_EN
        .c_xnor(n1_xnor), .err(err1)
`else
        .c_xnor(n1_xnor)
`endif
    );

    structural_level #(.WIDTH(4)) u_d4 (
        .clk(clk), .rst(rst), .en(en4), .a(a4), .b(b4),
        .c_not_a(n4_not_a), .c_not_b(n4_not_b), .c_and(n4_and), .c_or(n4_or),
        .c_xor(n4_xor), .c_nand(n4_nand), .c_nor(n4_nor),
`ifdef STRUCTURAL_LEVEL_SELFCHECK_EN
        .c_xnor(n4_xnor), .err(err4)
`else
        .c_xnor(n4_xnor)
`endif
    );

    // Output order everywhere: {not_a, not_b, and, or, xor, nand, nor, xnor}
    wire [7:0]  out1 = {n1_not_a, n1_not_b, n1_and, n1_or, n1_xor, n1_nand, n1_nor, n1_xnor};
    wire [31:0] out4 = {n4_not_a, n4_not_b, n4_and, n4_or, n4_xor, n4_nand, n4_nor, n4_xnor};

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_next(input string name, input logic [31:0] act);
        logic [31:0] exp;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: expected queue empty at %0t", name, $time);
        end else begin
            exp = exp_q.pop_front();
            check(name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic e1, input logic e4,
                         input logic [0:0] xa1, input logic [0:0] xb1,
                         input logic [3:0] xa4, input logic [3:0] xb4);
        rst = r; en1 = e1; en4 = e4;
        a1 = xa1; b1 = xb1; a4 = xa4; b4 = xb4;
    endtask

    // ---------------- vectors ----------------
    typedef struct packed {
        logic [0:0]  a1;
        logic [0:0]  b1;
        logic [7:0]  exp1;
        logic [3:0]  a4;
        logic [3:0]  b4;
        logic [31:0] exp4;
    } vec_t;

    vec_t vecs[4];

`ifdef STRUCTURAL_LEVEL_SELFCHECK_EN
    function automatic logic [31:0] model4(input logic [3:0] x, input logic [3:0] y);
        return {~x, ~y, x & y, x | y, x ^ y, ~(x & y), ~(x | y), ~(x ^ y)};
    endfunction
`endif

    initial begin
        vecs[0] = '{1'b0, 1'b0, 8'b1100_0111, 4'b1100, 4'b1010,
                    {4'b0011, 4'b0101, 4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001}};
        vecs[1] = '{1'b0, 1'b1, 8'b1001_1100, 4'b0000, 4'b1111,
                    {4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000}};
        vecs[2] = '{1'b1, 1'b0, 8'b0101_1100, 4'b0101, 4'b0011,
                    {4'b1010, 4'b1100, 4'b0001, 4'b0111, 4'b0110, 4'b1110, 4'b1000, 4'b1001}};
        vecs[3] = '{1'b1, 1'b1, 8'b0011_0001, 4'b1111, 4'b1111,
                    {4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b1111}};

        // Reset held two cycles: everything zero, not the gate values for a=b=0.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("reset_w1", {24'h0, out1}, 32'h0);
            check("reset_w4", out4, 32'h0);
        end

        // Truth table, one vector per clock, result one edge later.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b1, vecs[i].a1, vecs[i].b1, vecs[i].a4, vecs[i].b4);
            exp_q.push_back({24'h0, vecs[i].exp1});
            exp_q.push_back(vecs[i].exp4);
            tick();
            check_next("table_w1", {24'h0, out1});
            check_next("table_w4", out4);
        end

        // Reset with a=b=0 gives zeros; release gives c_nand=1 one edge later.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        tick();
        check("rst_zero_w1", {24'h0, out1}, 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        tick();
        check("rst_release_nand", {31'h0, n1_nand}, 32'h1);
        check("rst_release_w1", {24'h0, out1}, {24'h0, vecs[0].exp1});

        // Hold: capture 1,1 then en=0 with 0,0 for three clocks.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 4'hF);
        tick();
        check("hold_capture", {24'h0, out1}, {24'h0, vecs[3].exp1});
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_and", {31'h0, n1_and}, 32'h1);
            check("hold_nor", {31'h0, n1_nor}, 32'h0);
            check("hold_w4", out4, vecs[3].exp4);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        tick();
        check("unhold_and", {31'h0, n1_and}, 32'h0);
        check("unhold_nor", {31'h0, n1_nor}, 32'h1);

        // Mid-operation reset with en low: reset still wins.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0101, 4'b0011);
        tick();
        check("midop_pre_w4", out4, vecs[2].exp4);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1100, 4'b1010);
        tick();
        check("midop_rst_w1", {24'h0, out1}, 32'h0);
        check("midop_rst_w4", out4, 32'h0);
        // First edge after release with en=0 on d1: stays zero; d4 captures.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1100, 4'b1010);
        tick();
        check("midop_noen_w1", {24'h0, out1}, 32'h0);
        check("midop_resume_w4", out4, vecs[0].exp4);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b1111);
        tick();
        check("midop_resume_w1", {24'h0, out1}, {24'h0, vecs[2].exp1});
        check("midop_next_w4", out4, vecs[1].exp4);

`ifdef STRUCTURAL_LEVEL_SELFCHECK_EN
        // Exhaustive sweep: outputs follow the bitwise model, err never rises.
        for (int i = 0; i < 256; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, i[7:4], i[3:0]);
            tick();
            check("sweep_w4", out4, model4(i[7:4], i[3:0]));
            check("sweep_err4", {31'h0, err4}, 32'h0);
        end
        check("sweep_err1", {31'h0, err1}, 32'h0);

        // Corrupt one nand bit after a capture of a=b=0 (nand should be 1111).
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        tick();
        force u_d4.nand_q = 4'b1110;
        tick();
        check("force_err_set", {31'h0, err4}, 32'h1);
        release u_d4.nand_q;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("force_err_sticky", {31'h0, err4}, 32'h1);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        tick();
        check("force_err_clear", {31'h0, err4}, 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        tick();
        tick();
        check("post_clear_err", {31'h0, err4}, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/structural_level.md
Name: structural_level

Overview:
- Basic two-input logic-gate block.
- Computes NOT of each operand and AND, OR, XOR, NAND, NOR, XNOR of the operand pair, bit-wise across a WIDTH-bit vector.
- Gate network is built structurally from gate primitives, one instance per bit per function, in a generate loop.
- All results are captured in output registers, giving a one-cycle-latency, clean-timing gate library stage for small datapaths and for gate-level training/verification.

Parameters:
- WIDTH, 1, operand and result width in bits (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  capture enable; when low, all result registers hold.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_not_a  output  WIDTH  registered ~a.
- c_not_b  output  WIDTH  registered ~b.
- c_and  output  WIDTH  registered a & b.
- c_or  output  WIDTH  registered a | b.
- c_xor  output  WIDTH  registered a ^ b.
- c_nand  output  WIDTH  registered ~(a & b).
- c_nor  output  WIDTH  registered ~(a | b).
- c_xnor  output  WIDTH  registered ~(a ^ b).

Behaviour:
- Combinational stage:
  - Per bit i, eight primitive gates (not, not, and, or, xor, nand, nor, xnor) drive internal nets.
  - No behavioural operators in the gate stage.
- Register stage, on rising clk:
  - rst=1: all eight outputs forced to all-zeros. rst has priority over en.
  - rst=0, en=1: every output register loads its gate net.
  - rst=0, en=0: every output register holds its value.
- Latency:
  - Exactly one clock from a/b sampled with en=1 to the corresponding outputs.
  - No combinational path from inputs to outputs.
- Reset values:
  - All outputs are 0 after reset, including c_nand, c_nor, c_xnor and c_not_*.
  - These values are not logically consistent with any input; consumers must ignore outputs until the first enabled capture after reset.
- Reset mid-operation: rst asserted at any edge zeroes the outputs at that edge, whatever en is. The first capture after release occurs at the first edge with rst=0 and en=1.
- Bit independence: bit i of every output depends only on a[i] and b[i]. There is no carry or cross-bit logic.
- Invariants after any enabled capture:
  - c_nand == ~c_and
  - c_nor == ~c_or
  - c_xnor == ~c_xor
  - c_not_a ^ c_not_b == c_xor
- X handling: no special handling; X inputs propagate per the primitive gates.

Optional Feature:
- Macro: STRUCTURAL_LEVEL_SELFCHECK_EN.
- When defined:
  - Adds output port err (1 bit, registered).
  - err resets to 0 via rst.
  - On each edge with rst=0, err is set to 1 if any invariant above is violated by the current registered outputs (only evaluated when a capture occurred on the previous edge).
  - err is sticky until rst.
  - The check logic is built from xor/or primitives plus a reduction.
- When undefined: the err port and all check logic are absent; the block is otherwise identical.

Test Plan:
- WIDTH=1, rst held 2 cycles then released, en=1, apply a/b = 00, 01, 10, 11 for one clock each (10 ns period). Required outputs one clock later, each listed as not_a, not_b, and, or, xor, nand, nor, xnor:
  - 00 -> 1,1,0,0,0,1,1,1
  - 01 -> 1,0,0,1,1,1,0,0
  - 10 -> 0,1,0,1,1,1,0,0
  - 11 -> 0,0,1,1,0,0,0,1
- Reset check: rst=1 with a=0, b=0 -> all outputs 0 (not 1) at the next edge. Release rst -> c_nand=1 one edge later.
- Hold: after capturing a=1, b=1, drive en=0 and a=0, b=0 for 3 clocks -> c_and stays 1 and c_nor stays 0. Raise en -> c_and=0 and c_nor=1 next edge.
- WIDTH=4: a=4'b1100, b=4'b1010 -> c_and=1000, c_or=1110, c_xor=0110, c_nand=0111, c_nor=0001, c_xnor=1001, c_not_a=0011, c_not_b=0101.
- Mid-operation reset: en=1 with changing inputs, assert rst for one edge -> all outputs 0 at that edge; correct results resume one edge after rst deasserts.
- With STRUCTURAL_LEVEL_SELFCHECK_EN defined, run exhaustive WIDTH=4 sweep (256 a/b pairs) -> err remains 0 throughout; force an internal c_nand register bit -> err=1 next edge and stays 1 until rst.
